data_path_loader: RTL and testbench

- Sequencer in front of the data_path storages (code, input, label, weight).
- Accepts load jobs from the host, then streams payload words into the selected storage, generating auto-incrementing layer/row or line indices.
- After each load it pulses the matrix-storage locator reset.
- On request it enables the controller and code storage for a run, and holds them until the run completes.

---
 rtl/data_path_loader_pkg.sv | 38 +++
 rtl/data_path_loader_index_counter.sv | 67 ++++++
 rtl/data_path_loader.sv | 237 +++++++++++++++++++++++
 tb/tb_data_path_loader.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_path_loader_pkg.sv
// -----------------------------------------------------------------------------
// data_path_loader_pkg
//
// Shared types and default widths for the data_path loader sequencer.
//   target_e : storage selected by a load job (code, input, label, weight)
//   state_e  : loader sequencer states
//   *_DEF    : default widths used as parameter defaults by the loader
//   is_empty_job : true when a job descriptor carries no payload
// -----------------------------------------------------------------------------
package data_path_loader_pkg;

  localparam int IDX_W_DEF   = 32;
  localparam int DATA_W_DEF  = 48;
  localparam int CODE_W_DEF  = 12;
  localparam int NUM_TARGETS = 4;

  typedef enum logic [1:0] {
    CODE   = 2'd0,
    INPUT  = 2'd1,
    LABEL  = 2'd2,
    WEIGHT = 2'd3
  } target_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    LOC_RST = 2'd2,
    RUN     = 2'd3
  } state_e;

  // A job with zero layers or zero rows would never reach its last word, so
  // it is rejected up front instead of being loaded.
  function automatic logic is_empty_job(input logic any_layers,
                                        input logic any_rows);
    return !(any_layers && any_rows);
  endfunction

endpackage

// File: rtl/data_path_loader_index_counter.sv
// -----------------------------------------------------------------------------
// dp_index_counter
//
// Write-address generator for the loader: a 2-D row/layer counter that wraps
// the row at rows-1 and then advances the layer, plus a linear line counter
// that advances on every step regardless of the wrap.
//
// Ports
//   clk_clk     in   clock
//   reset_reset in   synchronous active-high reset
//   clear       in   synchronous clear of all counters
//   step        in   advance by one word
//   layers      in   number of layers of the active job
//   rows        in   rows per layer of the active job
//   layer       out  current layer index
//   row         out  current row index
//   line        out  current linear line index
//   last        out  current position is the final word of the job
// -----------------------------------------------------------------------------
module dp_index_counter #(
  parameter int IDX_W = 32
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic             clear,
  input  logic             step,
  input  logic [IDX_W-1:0] layers,
  input  logic [IDX_W-1:0] rows,
  output logic [IDX_W-1:0] layer,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] line,
  output logic             last
);

  localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

  logic [IDX_W-1:0] layer_reg;
  logic [IDX_W-1:0] row_reg;
  logic [IDX_W-1:0] line_reg;
  logic             row_wrap;

  // Per-dimension compares keep termination correct even when the product
  // layers*rows would overflow IDX_W.
  assign row_wrap = (row_reg == rows - ONE);
  assign last     = row_wrap && (layer_reg == layers - ONE);

  always_ff @(posedge clk_clk) begin
    if (reset_reset || clear) begin
      layer_reg <= '0;
      row_reg   <= '0;
      line_reg  <= '0;
    end else if (step) begin
      line_reg <= line_reg + ONE;
      if (row_wrap) begin
        row_reg   <= '0;
        layer_reg <= layer_reg + ONE;
      end else begin
        row_reg <= row_reg + ONE;
      end
    end
  end

  assign layer = layer_reg;
  assign row   = row_reg;
  assign line  = line_reg;

endmodule

// File: rtl/data_path_loader.sv
// -----------------------------------------------------------------------------
// data_path_loader
//
// Sequencer in front of the data_path storages. Accepts load jobs, streams
// payload words into the selected storage with auto-incrementing layer/row
// and line indices, pulses the matrix-storage locator reset after each load,
// and enables the controller plus code storage for a run until run_done.
//
// Ports
//   clk_clk, reset_reset           clock, synchronous active-high reset
//   job_valid/job_ready            job descriptor handshake
//   job_target/job_layers/job_rows job descriptor fields
//   data_valid/data_ready/data_word payload word handshake
//   start_run, run_done            run request and run-complete indication
//   abort                          (only with DP_LOADER_ABORT_EN) abort load/run
//   *_is_write                     one-cycle write strobes per storage
//   wr_layer_index/wr_row_index/wr_line/wr_data  registered write address/data
//   locator_reset                  one-cycle locator reset pulse
//   controller_enable, code_storage_enable  held high during a run
//   busy                           loader not idle
//   job_error                      one-cycle pulse on a rejected job
//
// Build option: define DP_LOADER_ABORT_EN to add the abort input.
// -----------------------------------------------------------------------------
module data_path_loader
  import data_path_loader_pkg::*;
#(
  parameter int IDX_W  = IDX_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CODE_W = CODE_W_DEF
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [1:0]        job_target,
  input  logic [IDX_W-1:0]  job_layers,
  input  logic [IDX_W-1:0]  job_rows,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic [DATA_W-1:0] data_word,
  input  logic              start_run,
`ifdef DP_LOADER_ABORT_EN
  input  logic              abort,
`endif
  input  logic              run_done,
  output logic              code_is_write,
  output logic              input_is_write,
  output logic              label_is_write,
  output logic              weight_is_write,
  output logic [IDX_W-1:0]  wr_layer_index,
  output logic [IDX_W-1:0]  wr_row_index,
  output logic [IDX_W-1:0]  wr_line,
  output logic [DATA_W-1:0] wr_data,
  output logic              locator_reset,
  output logic              controller_enable,
  output logic              code_storage_enable,
  output logic              busy,
  output logic              job_error
);

  genvar gi;

  state_e            state_reg;
  state_e            state_next;
  target_e           target_reg;
  logic [IDX_W-1:0]  layers_reg;
  logic [IDX_W-1:0]  rows_reg;

  logic              abort_req;
  logic              job_take;
  logic              job_bad;
  logic              wr_fire;
  logic              cnt_last;
  logic [IDX_W-1:0]  cnt_layer;
  logic [IDX_W-1:0]  cnt_row;
  logic [IDX_W-1:0]  cnt_line;
  logic [DATA_W-1:0] data_masked;

  logic [NUM_TARGETS-1:0] strobe_next;
  logic [NUM_TARGETS-1:0] strobe_reg;
  logic [IDX_W-1:0]       wr_layer_reg;
  logic [IDX_W-1:0]       wr_row_reg;
  logic [IDX_W-1:0]       wr_line_reg;
  logic [DATA_W-1:0]      wr_data_reg;
  logic                   job_error_reg;

`ifdef DP_LOADER_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Job acceptance happens in IDLE only; a job always takes priority over a
  // simultaneous start_run.
  assign job_take = (state_reg == IDLE) && job_valid;
  assign job_bad  = is_empty_job(|job_layers, |job_rows);

  // A handshaken word is written unless an abort arrives in the same cycle,
  // in which case the pending write is discarded.
  assign wr_fire = (state_reg == LOAD) && data_valid && !abort_req;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (job_valid) begin
          if (!job_bad) begin
            state_next = LOAD;
          end
        end else if (start_run) begin
          state_next = RUN;
        end
      end
      LOAD: begin
        if (abort_req || (data_valid && cnt_last)) begin
          state_next = LOC_RST;
        end
      end
      LOC_RST: begin
        state_next = IDLE;
      end
      RUN: begin
        if (abort_req || run_done) begin
          state_next = LOC_RST;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Job descriptor latch and error pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      target_reg    <= CODE;
      layers_reg    <= '0;
      rows_reg      <= '0;
      job_error_reg <= 1'b0;
    end else begin
      job_error_reg <= job_take && job_bad;
      if (job_take && !job_bad) begin
        target_reg <= target_e'(job_target);
        layers_reg <= job_layers;
        rows_reg   <= job_rows;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Index generation; counters sit at zero whenever the loader is not loading.
  // ---------------------------------------------------------------------------
  dp_index_counter #(
    .IDX_W (IDX_W)
  ) u_index_counter (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .clear       (state_reg != LOAD),
    .step        (wr_fire),
    .layers      (layers_reg),
    .rows        (rows_reg),
    .layer       (cnt_layer),
    .row         (cnt_row),
    .line        (cnt_line),
    .last        (cnt_last)
  );

  // ---------------------------------------------------------------------------
  // Write port: one registered strobe per storage, shared address and data.
  // ---------------------------------------------------------------------------
  generate
    for (gi = 0; gi < NUM_TARGETS; gi++) begin : g_strobe
      assign strobe_next[gi] = wr_fire && (target_reg == target_e'(2'(gi)));
    end
  endgenerate

  // Code storage only holds CODE_W bits; the rest of the word is zeroed.
  assign data_masked = (target_reg == CODE)
                     ? {{(DATA_W-CODE_W){1'b0}}, data_word[CODE_W-1:0]}
                     : data_word;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      strobe_reg   <= '0;
      wr_layer_reg <= '0;
      wr_row_reg   <= '0;
      wr_line_reg  <= '0;
      wr_data_reg  <= '0;
    end else begin
      strobe_reg <= strobe_next;
      if (wr_fire) begin
        wr_layer_reg <= cnt_layer;
        wr_row_reg   <= cnt_row;
        wr_line_reg  <= cnt_line;
        wr_data_reg  <= data_masked;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign job_ready           = (state_reg == IDLE);
  assign data_ready          = (state_reg == LOAD);
  assign busy                = (state_reg != IDLE);
  assign locator_reset       = (state_reg == LOC_RST);
  assign controller_enable   = (state_reg == RUN);
  assign code_storage_enable = (state_reg == RUN);
  assign job_error           = job_error_reg;

  assign code_is_write   = strobe_reg[CODE];
  assign input_is_write  = strobe_reg[INPUT];
  assign label_is_write  = strobe_reg[LABEL];
  assign weight_is_write = strobe_reg[WEIGHT];
  assign wr_layer_index  = wr_layer_reg;
  assign wr_row_index    = wr_row_reg;
  assign wr_line         = wr_line_reg;
  assign wr_data         = wr_data_reg;

endmodule

// File: tb/tb_data_path_loader.sv
// -----------------------------------------------------------------------------
// tb_data_path_loader
//
// Self-checking bench for data_path_loader. A monitor keeps a queue of the
// writes every payload handshake must produce (indices derived from the word
// ordinal within the job) and checks each strobe against it; directed and
// randomized jobs and runs drive the loader.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_data_path_loader;
  import data_path_loader_pkg::*;

  localparam int IDX_W  = 32;
  localparam int DATA_W = 48;

  logic              clk_clk = 1'b0;
  logic              reset_reset;
  logic              job_valid;
  logic              job_ready;
  logic [1:0]        job_target;
  logic [IDX_W-1:0]  job_layers;
  logic [IDX_W-1:0]  job_rows;
  logic              data_valid;
  logic              data_ready;
  logic [DATA_W-1:0] data_word;
  logic              start_run;
  logic              run_done;
  logic              abort;
  logic              code_is_write;
  logic              input_is_write;
  logic              label_is_write;
  logic              weight_is_write;
  logic [IDX_W-1:0]  wr_layer_index;
  logic [IDX_W-1:0]  wr_row_index;
  logic [IDX_W-1:0]  wr_line;
  logic [DATA_W-1:0] wr_data;
  logic              locator_reset;
  logic              controller_enable;
  logic              code_storage_enable;
  logic              busy;
  logic              job_error;

  data_path_loader dut (
    .clk_clk             (clk_clk),
    .reset_reset         (reset_reset),
    .job_valid           (job_valid),
    .job_ready           (job_ready),
    .job_target          (job_target),
    .job_layers          (job_layers),
    .job_rows            (job_rows),
    .data_valid          (data_valid),
    .data_ready          (data_ready),
    .data_word           (data_word),
    .start_run           (start_run),
`ifdef DP_LOADER_ABORT_EN
    .abort               (abort),
`endif
    .run_done            (run_done),
    .code_is_write       (code_is_write),
    .input_is_write      (input_is_write),
    .label_is_write      (label_is_write),
    .weight_is_write     (weight_is_write),
    .wr_layer_index      (wr_layer_index),
    .wr_row_index        (wr_row_index),
    .wr_line             (wr_line),
    .wr_data             (wr_data),
    .locator_reset       (locator_reset),
    .controller_enable   (controller_enable),
    .code_storage_enable (code_storage_enable),
    .busy                (busy),
    .job_error           (job_error)
  );

  always #5 clk_clk = ~clk_clk;

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: expected writes derived from the word ordinal n within
  // the job: layer = n / rows, row = n % rows, line = n.
  // ---------------------------------------------------------------------------
  typedef struct {
    int                tgt;
    longint            layer;
    longint            row;
    longint            line;
    logic [DATA_W-1:0] data;
    int                cyc;
  } wr_t;

  wr_t pend[$];
  int  cyc      = 0;
  int  m_n      = 0;
  int  m_rows   = 1;
  int  m_tgt    = 0;
  int  wr_cnt   = 0;
  int  loc_cnt  = 0;
  int  jerr_cnt = 0;
  int  ce_cnt   = 0;
  int  cse_cnt  = 0;

  always @(posedge clk_clk) cyc <= cyc + 1;

  always @(negedge clk_clk) begin : monitor
    logic [3:0] sv;
    wr_t        it;
    wr_t        nw;
    sv = {weight_is_write, label_is_write, input_is_write, code_is_write};
    if (sv != 4'b0) begin
      wr_cnt++;
      if (pend.size() == 0) begin
        check("spurious_write", 64'(sv), 64'd0);
      end else begin
        it = pend.pop_front();
        check("wr_latency", 64'(cyc), 64'(it.cyc));
        check("wr_strobe", 64'(sv), 64'(4'b0001 << it.tgt));
        check("wr_layer", 64'(wr_layer_index), 64'(it.layer));
        check("wr_row", 64'(wr_row_index), 64'(it.row));
        check("wr_line", 64'(wr_line), 64'(it.line));
        check("wr_data", 64'(wr_data), 64'(it.data));
      end
    end
    if (reset_reset) begin
      pend.delete();
    end else begin
      if (job_valid && job_ready && job_layers != 0 && job_rows != 0) begin
        m_n    = 0;
        m_rows = int'(job_rows);
        m_tgt  = int'(job_target);
      end
      if (data_valid && data_ready) begin
        nw.tgt   = m_tgt;
        nw.layer = longint'(m_n / m_rows);
        nw.row   = longint'(m_n % m_rows);
        nw.line  = longint'(m_n);
        nw.data  = (m_tgt == 0) ? (data_word & 48'hFFF) : data_word;
        nw.cyc   = cyc + 1;
        pend.push_back(nw);
        m_n++;
      end
    end
    if (locator_reset) loc_cnt++;
    if (job_error) jerr_cnt++;
    if (controller_enable) ce_cnt++;
    if (code_storage_enable) cse_cnt++;
  end

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  function automatic logic [DATA_W-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DATA_W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!job_ready && n < 40) begin
      tick();
      n++;
    end
    if (!job_ready) check("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_job_ready"}, 64'(job_ready), 64'd1);
    check({tag, "_data_ready"}, 64'(data_ready), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_strobes"}, 64'({weight_is_write, label_is_write, input_is_write, code_is_write}), 64'd0);
    check({tag, "_locator_reset"}, 64'(locator_reset), 64'd0);
    check({tag, "_enables"}, 64'({controller_enable, code_storage_enable}), 64'd0);
    check({tag, "_job_error"}, 64'(job_error), 64'd0);
    check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    check({tag, "_wr_idx"}, 64'(wr_layer_index | wr_row_index | wr_line), 64'd0);
  endtask

  // run_mode: 0 none, 1 start_run together with job_valid, 2 start_run held
  // throughout the load.
  task automatic do_job(input int tgt, input int layers, input int rows, input bit gaps,
                        input bit fixed, input logic [DATA_W-1:0] word, input int run_mode);
    int w0, l0, c0;
    wait_idle();
    w0 = wr_cnt; l0 = loc_cnt; c0 = ce_cnt;
    job_target = 2'(tgt);
    job_layers = IDX_W'(layers);
    job_rows   = IDX_W'(rows);
    job_valid  = 1'b1;
    if (run_mode != 0) start_run = 1'b1;
    tick();
    job_valid = 1'b0;
    if (run_mode == 1) start_run = 1'b0;
    for (int i = 0; i < layers * rows; i++) begin
      if (gaps) begin
        data_valid = 1'b0;
        tick();
      end
      data_valid = 1'b1;
      data_word  = fixed ? word : rand_word();
      check("load_data_ready", 64'(data_ready), 64'd1);
      tick();
    end
    data_valid = 1'b0;
    start_run  = 1'b0;
    check("load_done_data_ready", 64'(data_ready), 64'd0);
    wait_idle();
    tick();
    check("job_write_count", 64'(wr_cnt - w0), 64'(layers * rows));
    check("job_locator_pulses", 64'(loc_cnt - l0), 64'd1);
    check("job_no_run", 64'(ce_cnt - c0), 64'd0);
    check("job_pending_empty", 64'(pend.size()), 64'd0);
    $display("job tgt=%0d layers=%0d rows=%0d gaps=%0d run_mode=%0d writes=%0d",
             tgt, layers, rows, gaps, run_mode, wr_cnt - w0);
  endtask

  task automatic bad_job(input int layers, input int rows);
    int e0, w0;
    wait_idle();
    e0 = jerr_cnt; w0 = wr_cnt;
    job_target = 2'd1;
    job_layers = IDX_W'(layers);
    job_rows   = IDX_W'(rows);
    job_valid  = 1'b1;
    tick();
    job_valid = 1'b0;
    check("bad_job_busy", 64'(busy), 64'd0);
    repeat (3) tick();
    check("bad_job_error_pulses", 64'(jerr_cnt - e0), 64'd1);
    check("bad_job_writes", 64'(wr_cnt - w0), 64'd0);
    check("bad_job_ready", 64'(job_ready), 64'd1);
    $display("bad job layers=%0d rows=%0d error_pulses=%0d", layers, rows, jerr_cnt - e0);
  endtask

  task automatic do_run(input int ncyc);
    int c0, s0, l0;
    wait_idle();
    c0 = ce_cnt; s0 = cse_cnt; l0 = loc_cnt;
    start_run = 1'b1;
    tick();
    start_run = 1'b0;
    repeat (ncyc - 1) tick();
    run_done = 1'b1;
    tick();
    run_done = 1'b0;
    check("run_exit_enables", 64'({controller_enable, code_storage_enable}), 64'd0);
    repeat (3) tick();
    check("run_ctrl_cycles", 64'(ce_cnt - c0), 64'(ncyc));
    check("run_cs_cycles", 64'(cse_cnt - s0), 64'(ncyc));
    check("run_locator_pulses", 64'(loc_cnt - l0), 64'd1);
    check("run_back_idle", 64'(busy), 64'd0);
    $display("run cycles=%0d enable_cycles=%0d", ncyc, ce_cnt - c0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset_reset = 1'b1;
    job_valid   = 1'b0;
    job_target  = 2'd0;
    job_layers  = '0;
    job_rows    = '0;
    data_valid  = 1'b0;
    data_word   = '0;
    start_run   = 1'b0;
    run_done    = 1'b0;
    abort       = 1'b0;
    repeat (3) @(posedge clk_clk);
    #1;
    reset_reset = 1'b0;
    check_reset_outputs("reset");
    $display("reset released");

    // run_done outside RUN is ignored
    run_done = 1'b1;
    tick();
    run_done = 1'b0;
    check("idle_run_done_ignored", 64'(busy), 64'd0);

    do_job(1, 2, 3, 1'b0, 1'b0, '0, 0);
    do_job(0, 1, 4, 1'b0, 1'b1, 48'hFFFF_FFFF_FABC, 0);
    do_job(3, 3, 2, 1'b1, 1'b0, '0, 0);
    bad_job(2, 0);
    bad_job(0, 3);
    do_run(20);
    do_job(2, 2, 2, 1'b0, 1'b0, '0, 2);
    do_job(1, 1, 3, 1'b0, 1'b0, '0, 1);

    // Reset in the middle of a 2x3 load, after 2 words.
    wait_idle();
    job_target = 2'd1;
    job_layers = IDX_W'(2);
    job_rows   = IDX_W'(3);
    job_valid  = 1'b1;
    tick();
    job_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      data_valid = 1'b1;
      data_word  = rand_word();
      tick();
    end
    data_valid  = 1'b0;
    reset_reset = 1'b1;
    tick();
    reset_reset = 1'b0;
    check_reset_outputs("midload_reset");
    $display("reset applied mid-load after 2 words");
    do_job(1, 2, 3, 1'b0, 1'b0, '0, 0);

    for (int j = 0; j < 6; j++) begin
      do_job(int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
             int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), 1'b0, '0, 0);
    end
    do_run(int'($urandom_range(1, 8)));

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", err_cnt, chk_cnt);
    $fatal(1, "watchdog");
  end

endmodule
